// File: rtl/ezusb_gpio_filt.sv
// ezusb_gpio_filt: WIDTH low-active open-drain GPIOs with a synchroniser and a
// per-channel glitch filter on each input. Each channel has sticky rise and fall
// flags that are cleared by a strobe, and a registered summary interrupt.
// Optional macro GPIO_PULSE_EN adds the pulse_stb port. Each channel then gets a
// retriggerable counter that holds its pin low for PULSE_LEN cycles.
module ezusb_gpio_filt #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int PULSE_LEN   = 16
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [WIDTH-1:0] gpio_n,
    input  logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    input  logic [WIDTH-1:0] ev_clr,
    output logic             irq
`ifdef GPIO_PULSE_EN
    ,
    input  logic [WIDTH-1:0] pulse_stb
`endif
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    // Stop elaboration on parameter values the logic cannot support.
    if (WIDTH < 1 || SYNC_STAGES < 2 || FILTER_LEN < 1 || PULSE_LEN < 0) begin : g_bad_param
        $error("ezusb_gpio_filt: unsupported parameter value");
    end

    logic [WIDTH-1:0] drv;
    logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [CNT_W-1:0] cnt_reg  [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic [WIDTH-1:0] in_reg, in_next;
    logic [WIDTH-1:0] rise_reg, rise_next;
    logic [WIDTH-1:0] fall_reg, fall_next;
    logic [WIDTH-1:0] differ, done;
    logic             irq_reg;

    // Open-drain drive: pull the pin low or release it, with no register in the path.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
        assign gpio_n[gi] = drv[gi] ? 1'b0 : 1'bz;
    end

`ifdef GPIO_PULSE_EN
    localparam int PC_W = (PULSE_LEN > 0) ? $clog2(PULSE_LEN + 1) : 1;

    logic [PC_W-1:0] pc_reg  [WIDTH];
    logic [PC_W-1:0] pc_next [WIDTH];

    // A strobe reloads the counter, so a retrigger extends the pulse. A length of 0 ignores strobes.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pulse
        assign pc_next[gi] = (pulse_stb[gi] && PULSE_LEN != 0) ? PC_W'(PULSE_LEN) :
                             (pc_reg[gi] != '0) ? pc_reg[gi] - PC_W'(1) : '0;
        assign drv[gi]     = out[gi] | (pc_reg[gi] != '0);
    end

    // Pulse counters. Reset aborts any pulse in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) pc_reg[i] <= '0;
        end else begin
            pc_reg <= pc_next;
        end
    end
`else
    // Pulse support is compiled out, so the pins follow out directly.
    assign drv = out;
`endif

    // Synchroniser chain on the inverted pin, so 1 means the pin is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
        end else begin
            sync_reg[0] <= ~gpio_n;
            for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
        end
    end

    assign s = sync_reg[SYNC_STAGES-1];

    // Glitch filter: in follows s only after s has differed from in for FILTER_LEN
    // consecutive cycles. Any agreement in between restarts the count.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_filt
        assign differ[gi]   = s[gi] ^ in_reg[gi];
        assign done[gi]     = differ[gi] && (cnt_reg[gi] == CNT_LAST);
        assign cnt_next[gi] = (!differ[gi] || done[gi]) ? '0 : cnt_reg[gi] + CNT_W'(1);
        assign in_next[gi]  = done[gi] ? s[gi] : in_reg[gi];
    end

    // A new event takes priority over a clear arriving in the same cycle.
    assign rise_next = (done & s)  | (rise_reg & ~ev_clr);
    assign fall_next = (done & ~s) | (fall_reg & ~ev_clr);

    // Filter state, event flags and the summary interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) cnt_reg[i] <= '0;
            in_reg   <= '0;
            rise_reg <= '0;
            fall_reg <= '0;
            irq_reg  <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            in_reg   <= in_next;
            rise_reg <= rise_next;
            fall_reg <= fall_next;
            irq_reg  <= |(rise_reg | fall_reg);
        end
    end

    assign in   = in_reg;
    assign rise = rise_reg;
    assign fall = fall_reg;
    assign irq  = irq_reg;

endmodule

// File: tb/tb_ezusb_gpio_filt.sv
// Testbench for ezusb_gpio_filt (default parameters). Each scenario task pushes
// timed expectations into a scoreboard queue when it drives stimulus. The task
// pops and compares them when the DUT reaches the matching clock edge.
// The pulse scenario is built only when GPIO_PULSE_EN is defined.
module tb_ezusb_gpio_filt;

    localparam int K_IN = 0, K_RISE = 1, K_FALL = 2, K_IRQ = 3, K_PIN = 4;

    typedef struct {
        int    at;
        int    kind;
        int    ch;
        logic  val;
        string name;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    wire  [3:0] gpio_n;
    logic [3:0] out, in, rise, fall, ev_clr;
    logic       irq;
    logic [3:0] ext_low;
`ifdef GPIO_PULSE_EN
    logic [3:0] pulse_stb;
`endif

    exp_t sb[$];
    exp_t e;
    logic obs;
    int   edge_n = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    ezusb_gpio_filt dut (
        .clk    (clk),
        .reset  (reset),
        .gpio_n (gpio_n),
        .out    (out),
        .in     (in),
        .rise   (rise),
        .fall   (fall),
        .ev_clr (ev_clr),
        .irq    (irq)
`ifdef GPIO_PULSE_EN
        ,
        .pulse_stb (pulse_stb)
`endif
    );

    // The far end of each pin: a pull-up plus an optional external pull-down.
    for (genvar gi = 0; gi < 4; gi++) begin : g_far
        pullup (gpio_n[gi]);
        assign gpio_n[gi] = ext_low[gi] ? 1'b0 : 1'bz;
    end

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic expect_at(input int at, input int kind, input int ch, input logic val,
                             input string name);
        exp_t x;
        x.at = at; x.kind = kind; x.ch = ch; x.val = val; x.name = name;
        sb.push_back(x);
    endtask

    function automatic logic observe(input int kind, input int ch);
        case (kind)
            K_IN:    return in[ch];
            K_RISE:  return rise[ch];
            K_FALL:  return fall[ch];
            K_IRQ:   return irq;
            default: return gpio_n[ch];
        endcase
    endfunction

    task automatic test_reset();
        int t0 = edge_n;
        for (int k = 1; k <= 20; k++) begin
            expect_at(t0 + k, K_IRQ, 0, 1'b0, "reset_irq");
            for (int c = 0; c < 4; c++) begin
                expect_at(t0 + k, K_IN,   c, 1'b0, "reset_in");
                expect_at(t0 + k, K_RISE, c, 1'b0, "reset_rise");
                expect_at(t0 + k, K_FALL, c, 1'b0, "reset_fall");
                expect_at(t0 + k, K_PIN,  c, 1'b1, "reset_pin");
            end
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            while (sb.size() != 0 && sb[0].at <= edge_n) begin
                e = sb.pop_front(); n_cmp++; obs = observe(e.kind, e.ch);
                if (e.at != edge_n || obs !== e.val) begin
                    n_bad++;
                    $display("FAIL %s ch%0d edge %0d: got %b, want %b", e.name, e.ch, edge_n, obs, e.val);
                end
            end
        end
        reset = 1'b0;
        $display("test_reset: done at edge %0d", edge_n);
    endtask

    task automatic test_drive();
        int t0 = edge_n;
        out[2] = 1'b1;
        #1;
        n_cmp++;
        if (gpio_n[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL drive_pin_low: got %b, want 0", gpio_n[2]);
        end
        expect_at(t0 + 5, K_IN,   2, 1'b0, "drive_in_early");
        expect_at(t0 + 5, K_RISE, 2, 1'b0, "drive_rise_early");
        expect_at(t0 + 6, K_IN,   2, 1'b1, "drive_in");
        expect_at(t0 + 6, K_RISE, 2, 1'b1, "drive_rise");
        expect_at(t0 + 6, K_IRQ,  0, 1'b0, "drive_irq_early");
        expect_at(t0 + 7, K_IRQ,  0, 1'b1, "drive_irq");
        for (int k = 1; k <= 14; k++) begin
            tick();
            while (sb.size() != 0 && sb[0].at <= edge_n) begin
                e = sb.pop_front(); n_cmp++; obs = observe(e.kind, e.ch);
                if (e.at != edge_n || obs !== e.val) begin
                    n_bad++;
                    $display("FAIL %s ch%0d edge %0d: got %b, want %b", e.name, e.ch, edge_n, obs, e.val);
                end
            end
            if (k == 8) begin
                out[2] = 1'b0;
                #1;
                n_cmp++;
                if (gpio_n[2] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL drive_pin_release: got %b, want 1", gpio_n[2]);
                end
                expect_at(t0 + 13, K_FALL, 2, 1'b0, "drive_fall_early");
                expect_at(t0 + 14, K_FALL, 2, 1'b1, "drive_fall");
                expect_at(t0 + 14, K_IN,   2, 1'b0, "drive_in_low");
            end
        end
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL drive_pending: got %0d left, want 0", sb.size()); sb.delete();
        end
        $display("test_drive: done at edge %0d", edge_n);
    endtask

    task automatic test_glitch();
        int t0 = edge_n;
        for (int k = 1; k <= 22; k++) begin
            expect_at(t0 + k, K_IN, 1, (k >= 18 && k <= 21), "glitch_in");
            if (k == 17) expect_at(t0 + k, K_RISE, 1, 1'b0, "glitch_rise_early");
            if (k == 18) expect_at(t0 + k, K_RISE, 1, 1'b1, "glitch_rise");
            if (k == 21) expect_at(t0 + k, K_FALL, 1, 1'b0, "glitch_fall_early");
            if (k == 22) expect_at(t0 + k, K_FALL, 1, 1'b1, "glitch_fall");
        end
        ext_low[1] = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            tick();
            while (sb.size() != 0 && sb[0].at <= edge_n) begin
                e = sb.pop_front(); n_cmp++; obs = observe(e.kind, e.ch);
                if (e.at != edge_n || obs !== e.val) begin
                    n_bad++;
                    $display("FAIL %s ch%0d edge %0d: got %b, want %b", e.name, e.ch, edge_n, obs, e.val);
                end
            end
            if (k == 3)  ext_low[1] = 1'b0;
            if (k == 12) ext_low[1] = 1'b1;
            if (k == 16) ext_low[1] = 1'b0;
        end
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL glitch_pending: got %0d left, want 0", sb.size()); sb.delete();
        end
        $display("test_glitch: done at edge %0d", edge_n);
    endtask

    task automatic test_evclr();
        int t0 = edge_n;
        expect_at(t0 + 1,  K_RISE, 1, 1'b0, "clr_rise1");
        expect_at(t0 + 1,  K_RISE, 2, 1'b0, "clr_rise2");
        expect_at(t0 + 1,  K_FALL, 1, 1'b0, "clr_fall1");
        expect_at(t0 + 1,  K_FALL, 2, 1'b0, "clr_fall2");
        expect_at(t0 + 2,  K_IRQ,  0, 1'b0, "clr_irq");
        expect_at(t0 + 8,  K_IN,   2, 1'b1, "clr_in");
        expect_at(t0 + 8,  K_RISE, 2, 1'b1, "clr_rise_set");
        expect_at(t0 + 15, K_FALL, 2, 1'b0, "clr_fall_early");
        expect_at(t0 + 16, K_FALL, 2, 1'b1, "clr_set_wins");
        expect_at(t0 + 16, K_RISE, 2, 1'b0, "clr_rise_cleared");
        expect_at(t0 + 17, K_FALL, 2, 1'b1, "clr_fall_held");
        expect_at(t0 + 17, K_IRQ,  0, 1'b1, "clr_irq_held");
        expect_at(t0 + 18, K_RISE, 2, 1'b0, "clr2_rise");
        expect_at(t0 + 18, K_FALL, 2, 1'b0, "clr2_fall");
        expect_at(t0 + 18, K_IRQ,  0, 1'b1, "clr2_irq_lag");
        expect_at(t0 + 19, K_IRQ,  0, 1'b0, "clr2_irq_drop");
        ev_clr = 4'hF;
        for (int k = 1; k <= 19; k++) begin
            tick();
            while (sb.size() != 0 && sb[0].at <= edge_n) begin
                e = sb.pop_front(); n_cmp++; obs = observe(e.kind, e.ch);
                if (e.at != edge_n || obs !== e.val) begin
                    n_bad++;
                    $display("FAIL %s ch%0d edge %0d: got %b, want %b", e.name, e.ch, edge_n, obs, e.val);
                end
            end
            if (k == 1)  ev_clr = 4'h0;
            if (k == 2)  out[2] = 1'b1;
            if (k == 10) out[2] = 1'b0;
            if (k == 15) ev_clr = 4'b0100;
            if (k == 16) ev_clr = 4'h0;
            if (k == 17) ev_clr = 4'b0100;
            if (k == 18) ev_clr = 4'h0;
        end
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL clr_pending: got %0d left, want 0", sb.size()); sb.delete();
        end
        $display("test_evclr: done at edge %0d", edge_n);
    endtask

    task automatic test_reset_mid();
        int t0 = edge_n;
        expect_at(t0 + 5,  K_IN,   0, 1'b0, "rmid_in_early");
        expect_at(t0 + 6,  K_IN,   0, 1'b1, "rmid_in");
        expect_at(t0 + 6,  K_RISE, 0, 1'b1, "rmid_rise");
        expect_at(t0 + 9,  K_IN,   0, 1'b0, "rmid_in_reset");
        expect_at(t0 + 9,  K_RISE, 0, 1'b0, "rmid_rise_reset");
        expect_at(t0 + 10, K_IN,   0, 1'b0, "rmid_in_reset2");
        expect_at(t0 + 10, K_IRQ,  0, 1'b0, "rmid_irq_reset");
        expect_at(t0 + 15, K_IN,   0, 1'b0, "rmid_in_wait");
        expect_at(t0 + 15, K_RISE, 0, 1'b0, "rmid_rise_wait");
        expect_at(t0 + 16, K_IN,   0, 1'b1, "rmid_in_after");
        expect_at(t0 + 16, K_RISE, 0, 1'b1, "rmid_rise_after");
        expect_at(t0 + 16, K_FALL, 0, 1'b0, "rmid_no_fall");
        expect_at(t0 + 17, K_FALL, 0, 1'b0, "rmid_no_fall2");
        expect_at(t0 + 17, K_IRQ,  0, 1'b1, "rmid_irq");
        ext_low[0] = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            while (sb.size() != 0 && sb[0].at <= edge_n) begin
                e = sb.pop_front(); n_cmp++; obs = observe(e.kind, e.ch);
                if (e.at != edge_n || obs !== e.val) begin
                    n_bad++;
                    $display("FAIL %s ch%0d edge %0d: got %b, want %b", e.name, e.ch, edge_n, obs, e.val);
                end
            end
            if (k == 8)  reset = 1'b1;
            if (k == 10) reset = 1'b0;
        end
        ext_low[0] = 1'b0;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL rmid_pending: got %0d left, want 0", sb.size()); sb.delete();
        end
        $display("test_reset_mid: done at edge %0d", edge_n);
    endtask

`ifdef GPIO_PULSE_EN
    task automatic test_pulse();
        int t0 = edge_n;
        for (int k = 1; k <= 47; k++) begin
            expect_at(t0 + k, K_PIN, 0, !((k >= 1 && k <= 16) || (k >= 21 && k <= 46)), "pulse_pin");
        end
        pulse_stb[0] = 1'b1;
        for (int k = 1; k <= 47; k++) begin
            tick();
            while (sb.size() != 0 && sb[0].at <= edge_n) begin
                e = sb.pop_front(); n_cmp++; obs = observe(e.kind, e.ch);
                if (e.at != edge_n || obs !== e.val) begin
                    n_bad++;
                    $display("FAIL %s ch%0d edge %0d: got %b, want %b", e.name, e.ch, edge_n, obs, e.val);
                end
            end
            if (k == 1 || k == 21 || k == 31) pulse_stb[0] = 1'b0;
            if (k == 20 || k == 30)           pulse_stb[0] = 1'b1;
        end
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL pulse_pending: got %0d left, want 0", sb.size()); sb.delete();
        end
        $display("test_pulse: done at edge %0d", edge_n);
    endtask
`endif

    initial begin
        reset   = 1'b1;
        out     = 4'h0;
        ev_clr  = 4'h0;
        ext_low = 4'h0;
`ifdef GPIO_PULSE_EN
        pulse_stb = 4'h0;
`endif
        #1;
        test_reset();
        test_drive();
        test_glitch();
        test_evclr();
        test_reset_mid();
`ifdef GPIO_PULSE_EN
        test_pulse();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
